// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite command master: FSM state encoding and
// response codes.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        RESP
    } axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/axil_timeout_ctr.sv
// Per-channel wait counter; expired is high during the TIMEOUT_CYCLES-th
// enabled cycle since the last clear.
module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + CW'(1);
    end

    assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
// Define AXIL_MASTER_TIMEOUT_EN to bound every channel wait to TIMEOUT_CYCLES.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH_BITS  = 3,
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int TIMEOUT_CYCLES   = 16,
    localparam int DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [ADDR_WIDTH_BITS-1:0]  cmd_addr,
    input  logic [DATA_WIDTH_BITS-1:0]  cmd_wdata,
    input  logic [DATA_WIDTH_BYTES-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH_BITS-1:0]  rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    output logic [ADDR_WIDTH_BITS-1:0]  ARADDR,
    output logic [2:0]                  ARPROT,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic [DATA_WIDTH_BITS-1:0]  RDATA,
    input  logic [1:0]                  RRESP,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [ADDR_WIDTH_BITS-1:0]  AWADDR,
    output logic [2:0]                  AWPROT,
    output logic                        WVALID,
    input  logic                        WREADY,
    output logic [DATA_WIDTH_BITS-1:0]  WDATA,
    output logic [DATA_WIDTH_BYTES-1:0] WSTRB,
    input  logic                        BVALID,
    output logic                        BREADY,
    input  logic [1:0]                  BRESP
);

    axil_state_e state;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs, wr_both, advance, tmo;

    assign ARPROT = 3'b000;
    assign AWPROT = 3'b000;

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign wr_both = (aw_done || aw_hs) && (w_done || w_hs);

    // The awaited handshake of the current wait state; a timeout only fires without it.
    always_comb begin
        advance = 1'b0;
        case (state)
            RD_ADDR:      advance = ARREADY;
            RD_DATA:      advance = RVALID;
            WR_ADDR_DATA: advance = wr_both;
            WR_RESP:      advance = BVALID;
            default:      advance = 1'b0;
        endcase
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic wait_st;
    assign wait_st = (state == RD_ADDR) || (state == RD_DATA) ||
                     (state == WR_ADDR_DATA) || (state == WR_RESP);

    axil_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (!wait_st || advance),
        .enable  (wait_st),
        .expired (tmo)
    );
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            ARVALID   <= 1'b0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            RREADY    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            AWADDR    <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else if (tmo && !advance) begin
            ARVALID   <= 1'b0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            RREADY    <= 1'b0;
            BREADY    <= 1'b0;
            rsp_resp  <= RESP_SLVERR;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
        end else begin
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    ARADDR    <= cmd_addr;
                    AWADDR    <= cmd_addr;
                    WDATA     <= cmd_wdata;
                    WSTRB     <= cmd_wstrb;
                    if (cmd_write) begin
                        AWVALID <= 1'b1;
                        WVALID  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_ADDR_DATA;
                    end else begin
                        ARVALID <= 1'b1;
                        state   <= RD_ADDR;
                    end
                end
                RD_ADDR: if (ARREADY) begin
                    ARVALID <= 1'b0;
                    RREADY  <= 1'b1;
                    state   <= RD_DATA;
                end
                RD_DATA: if (RVALID) begin
                    RREADY    <= 1'b0;
                    rsp_rdata <= RDATA;
                    rsp_resp  <= RRESP;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                WR_ADDR_DATA: begin
                    // AW and W retire independently; B is awaited only once both have.
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (wr_both) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: if (BVALID) begin
                    BREADY    <= 1'b0;
                    rsp_resp  <= BRESP;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a 6-slot AXI4-Lite RAM model with per-channel
// ready delays, a response scoreboard and a channel-stability monitor.
module tb_axil_cmd_master;

    localparam int AW = 3, DB = 4, DW = 32, NSLOT = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DB-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [AW-1:0] ARADDR, AWADDR;
    logic [2:0]    ARPROT, AWPROT;
    logic [DW-1:0] RDATA, WDATA;
    logic [1:0]    RRESP, BRESP;
    logic [DB-1:0] WSTRB;

    axil_cmd_master #(.ADDR_WIDTH_BITS(AW), .DATA_WIDTH_BYTES(DB), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    // ---------------- slave model ----------------
    int ar_dly, aw_dly, w_dly, r_dly;
    int ar_cnt, aw_cnt, w_cnt, r_cnt;
    int aw_hs_n, w_hs_n, b_early;
    logic [DW-1:0] mem [NSLOT];
    logic          r_pend, aw_got, w_got;
    logic [AW-1:0] r_a, aw_a;
    logic [DW-1:0] w_d;
    logic [DB-1:0] w_s;

    assign ARREADY = (ar_cnt >= ar_dly);
    assign AWREADY = (aw_cnt >= aw_dly);
    assign WREADY  = (w_cnt >= w_dly);

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        if (int'(a) < NSLOT) return mem[a];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
            r_pend <= 1'b0; r_a <= '0; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'd0;
            BVALID <= 1'b0; BRESP <= 2'd0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_a <= '0; w_d <= '0; w_s <= '0;
            for (int i = 0; i < NSLOT; i++) mem[i] <= '0;
        end else begin
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            if (RVALID && RREADY) RVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                if (r_dly == 0) begin
                    RVALID <= 1'b1;
                    RDATA  <= rd_word(ARADDR);
                    RRESP  <= (int'(ARADDR) < NSLOT) ? 2'd0 : 2'd3;
                end else begin
                    r_pend <= 1'b1; r_a <= ARADDR; r_cnt <= 1;
                end
            end
            if (r_pend && !RVALID) begin
                if (r_cnt >= r_dly) begin
                    RVALID <= 1'b1;
                    RDATA  <= rd_word(r_a);
                    RRESP  <= (int'(r_a) < NSLOT) ? 2'd0 : 2'd3;
                    r_pend <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
            if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_a <= AWADDR; aw_hs_n <= aw_hs_n + 1; end
            if (WVALID && WREADY) begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; w_hs_n <= w_hs_n + 1; end
            if (aw_got && w_got && !BVALID) begin
                if (int'(aw_a) < NSLOT)
                    for (int b = 0; b < DB; b++)
                        if (w_s[b]) mem[aw_a][b*8 +: 8] <= w_d[b*8 +: 8];
                BVALID <= 1'b1;
                BRESP  <= (int'(aw_a) < NSLOT) ? 2'd0 : 2'd3;
            end
            if (BVALID && BREADY) begin BVALID <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
            if (BREADY && !(aw_got && w_got)) b_early <= b_early + 1;
        end
    end

    // ---------------- VALID stability monitor ----------------
    bit            mon_en;
    int            viol;
    logic          l_arv, l_arr, l_awv, l_awr, l_wv, l_wr, l_rst;
    logic [AW-1:0] l_ara, l_awa;
    logic [DW-1:0] l_wd;
    logic [DB-1:0] l_ws;

    always @(negedge clk) begin
        if (mon_en && !rst && !l_rst) begin
            if (l_arv && !l_arr && (!ARVALID || ARADDR !== l_ara)) viol <= viol + 1;
            if (l_awv && !l_awr && (!AWVALID || AWADDR !== l_awa)) viol <= viol + 1;
            if (l_wv && !l_wr && (!WVALID || WDATA !== l_wd || WSTRB !== l_ws)) viol <= viol + 1;
        end
        l_arv <= ARVALID; l_arr <= ARREADY; l_ara <= ARADDR;
        l_awv <= AWVALID; l_awr <= AWREADY; l_awa <= AWADDR;
        l_wv <= WVALID; l_wr <= WREADY; l_wd <= WDATA; l_ws <= WSTRB; l_rst <= rst;
    end

    // ---------------- checking ----------------
    typedef struct { logic [DW-1:0] rdata; logic [1:0] resp; } exp_t;
    exp_t sb[$];
    int n_cmp, n_bad;

    typedef struct {
        bit wr; logic [AW-1:0] a; logic [DW-1:0] d; logic [DB-1:0] s;
        int aw_d, w_d, ar_d, r_d, hold;
        logic [DW-1:0] er; logic [1:0] es;
    } vec_t;
    localparam int NV = 12;
    vec_t tv [NV];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", n, act, exp);
        end
    endtask

    task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DB-1:0] s);
        bit acc = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", {63'd0, acc}, 64'd1);
    endtask

    // Called right after send_cmd; lat counts edges from the accepting edge.
    task automatic get_rsp(input int hold, input string nm, output int lat);
        exp_t e;
        lat = 1;
        for (int i = 0; i < 200 && !rsp_valid; i++) begin @(posedge clk); #1; lat++; end
        chk({nm, " rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        if (!rsp_valid) return;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s scoreboard: got response, required none pending", nm);
            e.rdata = '0; e.resp = 2'd0;
        end else e = sb.pop_front();
        chk({nm, " rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        chk({nm, " resp"}, 64'(rsp_resp), 64'(e.resp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " hold valid"}, {63'd0, rsp_valid}, 64'd1);
            chk({nm, " hold rdata"}, 64'(rsp_rdata), 64'(e.rdata));
            chk({nm, " hold resp"}, 64'(rsp_resp), 64'(e.resp));
            chk({nm, " hold cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, " cmd_ready after rsp"}, {63'd0, cmd_ready}, 64'd1);
        chk({nm, " rsp_valid after rsp"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DB-1:0] s,
                       input logic [DW-1:0] er, input logic [1:0] es, input int hold, input string nm, output int lat);
        exp_t e;
        e.rdata = er; e.resp = es;
        sb.push_back(e);
        send_cmd(w, a, d, s);
        get_rsp(hold, nm, lat);
    endtask

    initial begin
        int lat, a0, w0;
        rst = 1'b1; mon_en = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0;

        tv[0]  = '{1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'd0};
        tv[1]  = '{1'b0, 3'd2, 32'h0,        4'h0, 0, 0, 2, 1, 0, 32'hDEADBEEF, 2'd0};
        tv[2]  = '{1'b1, 3'd1, 32'hFFFFFFFF, 4'hF, 1, 2, 0, 0, 0, 32'h0, 2'd0};
        tv[3]  = '{1'b1, 3'd1, 32'h00000012, 4'h1, 2, 0, 0, 0, 2, 32'h0, 2'd0};
        tv[4]  = '{1'b0, 3'd1, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'hFFFFFF12, 2'd0};
        tv[5]  = '{1'b0, 3'd7, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0, 2'd3};
        tv[6]  = '{1'b1, 3'd6, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'd3};
        tv[7]  = '{1'b0, 3'd0, 32'h0,        4'h0, 0, 0, 1, 0, 0, 32'h0, 2'd0};
        tv[8]  = '{1'b1, 3'd5, 32'hA5A5A5A5, 4'h6, 0, 1, 0, 0, 0, 32'h0, 2'd0};
        tv[9]  = '{1'b0, 3'd5, 32'h0,        4'h0, 0, 0, 0, 3, 0, 32'h00A5A500, 2'd0};
        tv[10] = '{1'b0, 3'd6, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0, 2'd3};
        tv[11] = '{1'b0, 3'd2, 32'h0,        4'h0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 2'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset rsp_resp", 64'(rsp_resp), 64'd0);
        chk("reset valid/ready", {59'd0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 64'd0);
        chk("reset addr/data", {ARADDR, AWADDR, WDATA, WSTRB}, 64'd0);
        chk("prot", {58'd0, ARPROT, AWPROT}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            aw_dly = tv[i].aw_d; w_dly = tv[i].w_d; ar_dly = tv[i].ar_d; r_dly = tv[i].r_d;
            a0 = aw_hs_n; w0 = w_hs_n;
            txn(tv[i].wr, tv[i].a, tv[i].d, tv[i].s, tv[i].er, tv[i].es, tv[i].hold, $sformatf("vec%0d", i), lat);
            if (tv[i].wr) begin
                chk($sformatf("vec%0d aw count", i), 64'(aw_hs_n - a0), 64'd1);
                chk($sformatf("vec%0d w count", i), 64'(w_hs_n - w0), 64'd1);
            end
        end
        ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0;

        // W accepted three cycles ahead of AW, then both in one cycle
        aw_dly = 3; w_dly = 0; a0 = aw_hs_n; w0 = w_hs_n;
        txn(1'b1, 3'd3, 32'h11223344, 4'hF, 32'h0, 2'd0, 0, "w_early", lat);
        chk("w_early aw count", 64'(aw_hs_n - a0), 64'd1);
        chk("w_early w count", 64'(w_hs_n - w0), 64'd1);
        aw_dly = 0; a0 = aw_hs_n; w0 = w_hs_n;
        txn(1'b1, 3'd4, 32'hCAFEF00D, 4'hF, 32'h0, 2'd0, 0, "w_same", lat);
        chk("w_same aw count", 64'(aw_hs_n - a0), 64'd1);
        chk("w_same w count", 64'(w_hs_n - w0), 64'd1);

        // zero-wait read latency, then a 5-cycle response stall
        txn(1'b0, 3'd4, 32'h0, 4'h0, 32'hCAFEF00D, 2'd0, 0, "lat0", lat);
        chk("lat0 latency", 64'(lat), 64'd3);
        txn(1'b0, 3'd3, 32'h0, 4'h0, 32'h11223344, 2'd0, 5, "stall", lat);

`ifdef AXIL_MASTER_TIMEOUT_EN
        ar_dly = 1000; mon_en = 1'b0;
        txn(1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 2'd2, 0, "tmo", lat);
        chk("tmo latency", 64'(lat), 64'd17);
        chk("tmo ARVALID", {63'd0, ARVALID}, 64'd0);
        ar_dly = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
`else
        ar_dly = 30;
        txn(1'b0, 3'd2, 32'h0, 4'h0, 32'hDEADBEEF, 2'd0, 0, "long_ar", lat);
        chk("long_ar latency", 64'(lat), 64'd33);
        ar_dly = 0;
`endif

        // reset while the master waits in RD_DATA
        r_dly = 20;
        send_cmd(1'b0, 3'd2, 32'h0, 4'h0);
        for (int i = 0; i < 50 && !RREADY; i++) begin @(posedge clk); #1; end
        chk("midrst RREADY seen", {63'd0, RREADY}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("midrst RREADY", {63'd0, RREADY}, 64'd0);
        chk("midrst ARVALID", {63'd0, ARVALID}, 64'd0);
        chk("midrst rsp_valid", {63'd0, rsp_valid}, 64'd0);
        r_dly = 0;
        txn(1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 2'd0, 0, "post_rst", lat);

        repeat (2) @(posedge clk);
        #1;
        chk("valid stability", 64'(viol), 64'd0);
        chk("bready early", 64'(b_early), 64'd0);
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
